pulse_to_level: RTL and testbench

PULSE_TO_LEVEL -- requirements
Module: pulse_to_level

---
 rtl/pulse_to_level.sv | 107 ++++++++++
 tb/tb_pulse_to_level.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pulse_to_level.sv
// Stretches single-cycle event pulses into acknowledged levels, queueing events
// that arrive while a previous one is still being presented.
module pulse_to_level #(
   parameter int HIGH_MIN = 4,
   parameter int GAP      = 1,
   parameter int PEND_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   input  logic              ack_in,
   input  logic              clr_overflow,
   output logic              level_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int HCW = (HIGH_MIN > 1) ? $clog2(HIGH_MIN) : 1;
   localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HIGH     = 2'd1,
      WAIT_ACK = 2'd2,
      GAP_ST   = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [HCW-1:0] high_cnt;
   logic [GCW-1:0] gap_cnt;
   logic           high_last;
   logic           gap_last;
   logic           pend_inc;
   logic           pend_dec;
   logic           drop;

   assign high_last = (high_cnt == HCW'(HIGH_MIN - 1));
   assign gap_last  = (gap_cnt == GCW'(GAP - 1));

   // A pulse in IDLE with nothing queued is served directly; every other pulse
   // is queued, and a queued event is consumed whenever IDLE finds one waiting.
   assign pend_inc = pulse_in && !((state == IDLE) && (pending == '0));
   assign pend_dec = (state == IDLE) && (pending != '0);
   assign drop     = pend_inc && !pend_dec && (pending == PEND_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         high_cnt <= '0;
         gap_cnt  <= '0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_next;
         high_cnt <= ((state == HIGH) && !high_last) ? high_cnt + HCW'(1) : '0;
         gap_cnt  <= ((state == GAP_ST) && !gap_last) ? gap_cnt + GCW'(1) : '0;
         if (pend_inc && !pend_dec && !drop) begin
            pending <= pending + PEND_W'(1);
         end else if (pend_dec && !pend_inc) begin
            pending <= pending - PEND_W'(1);
         end
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if ((pending != '0) || pulse_in) begin
               state_next = HIGH;
            end
         end
         HIGH: begin
            if (high_last) begin
               state_next = ack_in ? GAP_ST : WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_in) begin
               state_next = GAP_ST;
            end
         end
         GAP_ST: begin
            if (gap_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      level_out = (state == HIGH) || (state == WAIT_ACK);
      busy      = (state != IDLE);
   end

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level (HIGH_MIN=4, GAP=1, PEND_W=2) with
// hand-computed per-cycle expectations.
module tb_pulse_to_level;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pulse_in = 1'b0;
   logic       ack_in = 1'b0;
   logic       clr_overflow = 1'b0;
   logic       level_out;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   pulse_to_level #(.HIGH_MIN(4), .GAP(1), .PEND_W(2)) dut (
      .clk(clk),
      .rst(rst),
      .pulse_in(pulse_in),
      .ack_in(ack_in),
      .clr_overflow(clr_overflow),
      .level_out(level_out),
      .busy(busy),
      .pending(pending),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs, then sample just after the edge that consumes them.
   task automatic applyStimulus(input logic p, input logic a, input logic c, input logic r);
      pulse_in     = p;
      ack_in       = a;
      clr_overflow = c;
      rst          = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOne(input string tag, input logic [1:0] observed, input logic [1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input logic lvl, input logic bsy,
                              input logic [1:0] pnd, input logic ovf);
      checkOne({tag, ".level"}, {1'b0, level_out}, {1'b0, lvl});
      checkOne({tag, ".busy"}, {1'b0, busy}, {1'b0, bsy});
      checkOne({tag, ".pending"}, pending, pnd);
      checkOne({tag, ".overflow"}, {1'b0, overflow}, {1'b0, ovf});
   endtask

   initial begin
      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("reset", 1'b0, 1'b0, 2'd0, 1'b0);

      // Single event with ack held high
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("single.c1", 1'b1, 1'b1, 2'd0, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         checkOutput($sformatf("single.c%0d", k), 1'b1, 1'b1, 2'd0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("single.c5", 1'b0, 1'b1, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("single.c6", 1'b0, 1'b0, 2'd0, 1'b0);

      // Late acknowledge holds the level through WAIT_ACK
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("late.c1", 1'b1, 1'b1, 2'd0, 1'b0);
      for (int k = 2; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("late.c%0d", k), 1'b1, 1'b1, 2'd0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("late.c11", 1'b0, 1'b1, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("late.c12", 1'b0, 1'b0, 2'd0, 1'b0);

      // Queueing: pulses at cycles 0, 2, 3
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c3", 1'b1, 1'b1, 2'd1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c4", 1'b1, 1'b1, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c5", 1'b0, 1'b1, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c6", 1'b0, 1'b0, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c7", 1'b1, 1'b1, 2'd1, 1'b0);
      for (int k = 8; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("queue.c10", 1'b1, 1'b1, 2'd1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c11", 1'b0, 1'b1, 2'd1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c12", 1'b0, 1'b0, 2'd1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("queue.c13", 1'b1, 1'b1, 2'd0, 1'b0);
      for (int k = 14; k <= 18; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("queue.c18", 1'b0, 1'b0, 2'd0, 1'b0);

      // Simultaneous queued event and new pulse in IDLE
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("simul.c2", 1'b1, 1'b1, 2'd1, 1'b0);
      for (int k = 3; k <= 6; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("simul.c6", 1'b0, 1'b0, 2'd1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("simul.c7", 1'b1, 1'b1, 2'd1, 1'b0);

      // Saturation and sticky overflow
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("sat.reset", 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sat.c2", 1'b1, 1'b1, 2'd1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sat.c4", 1'b1, 1'b1, 2'd3, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sat.c5", 1'b1, 1'b1, 2'd3, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sat.c6", 1'b1, 1'b1, 2'd3, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("sat.clrdrop", 1'b1, 1'b1, 2'd3, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("sat.clr", 1'b1, 1'b1, 2'd3, 1'b0);

      // Reset while in WAIT_ACK with two events queued
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 4; k <= 6; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("rstmid.c6", 1'b1, 1'b1, 2'd2, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rstmid.after", 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("rstmid.ev.c1", 1'b1, 1'b1, 2'd0, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("rstmid.ev.c4", 1'b1, 1'b1, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rstmid.ev.c5", 1'b0, 1'b1, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rstmid.ev.c6", 1'b0, 1'b0, 2'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
